// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and memory.
// Handshake: the master raises imem_req with imem_addr and holds both steady
// until the slave returns imem_ready=1 for one cycle with imem_rdata valid in
// that same cycle; a request is never withdrawn before that completion.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, absorbs downstream freezes in a
// one-entry hold buffer, and redirects on taken branches without abandoning an
// outstanding memory request (pending fetches finish in DISCARD and are dropped).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [31:0]       branch_addr,
    if_stage_if.master        imem,
    output logic [31:0]       pc,
    output logic [31:0]       instruction,
    output logic              valid,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_reg_q, pc_reg_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instruction_q, instruction_d;
    logic        valid_q, valid_d;

    // Fetch addresses are kept word aligned; low bits of targets are ignored.
    logic [31:0] branch_tgt;
    logic [31:0] pc_plus4;
    assign branch_tgt = {branch_addr[31:2], 2'b00};
    assign pc_plus4   = pc_reg_q + 32'd4;

    // State and pipeline registers; reset wins over freeze and branch_taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_reg_q      <= {RESET_PC[31:2], 2'b00};
            redirect_pc_q <= 32'd0;
            hold_buf_q    <= 32'd0;
            pc_q          <= 32'd0;
            instruction_q <= 32'd0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_reg_q      <= pc_reg_d;
            redirect_pc_q <= redirect_pc_d;
            hold_buf_q    <= hold_buf_d;
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            valid_q       <= valid_d;
        end
    end

    // Next-state selection; branch_taken takes priority over freeze.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (branch_taken)
                    state_d = imem.imem_ready ? FETCH : DISCARD;
                else if (imem.imem_ready && freeze)
                    state_d = HOLD;
            end
            HOLD: begin
                if (branch_taken || !freeze)
                    state_d = FETCH;
            end
            DISCARD: begin
                if (imem.imem_ready)
                    state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Datapath: fetch address, redirect target, hold buffer and IF/ID register.
    always_comb begin
        pc_reg_d      = pc_reg_q;
        redirect_pc_d = redirect_pc_q;
        hold_buf_d    = hold_buf_q;
        pc_d          = pc_q;
        instruction_d = instruction_q;
        valid_d       = valid_q;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    pc_d          = 32'd0;
                    instruction_d = 32'd0;
                    valid_d       = 1'b0;
                    if (imem.imem_ready)
                        pc_reg_d = branch_tgt;
                    else
                        redirect_pc_d = branch_tgt;
                end else if (imem.imem_ready) begin
                    if (!freeze) begin
                        pc_d          = pc_plus4;
                        instruction_d = imem.imem_rdata;
                        valid_d       = 1'b1;
                        pc_reg_d      = pc_plus4;
                    end else begin
                        // pc_reg stays on the buffered word's address until release.
                        hold_buf_d = imem.imem_rdata;
                    end
                end else if (!freeze) begin
                    pc_d          = 32'd0;
                    instruction_d = 32'd0;
                    valid_d       = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d          = 32'd0;
                    instruction_d = 32'd0;
                    valid_d       = 1'b0;
                    hold_buf_d    = 32'd0;
                    pc_reg_d      = branch_tgt;
                end else if (!freeze) begin
                    pc_d          = pc_plus4;
                    instruction_d = hold_buf_q;
                    valid_d       = 1'b1;
                    pc_reg_d      = pc_plus4;
                end
            end
            DISCARD: begin
                pc_d          = 32'd0;
                instruction_d = 32'd0;
                valid_d       = 1'b0;
                if (branch_taken)
                    redirect_pc_d = branch_tgt;
                if (imem.imem_ready)
                    pc_reg_d = branch_taken ? branch_tgt : redirect_pc_q;
            end
            default: begin
                pc_reg_d = pc_reg_q;
            end
        endcase
    end

    // Outputs: request is suppressed in HOLD and whenever reset is asserted.
    always_comb begin
        imem.imem_req  = !rst && (state_q != HOLD);
        imem.imem_addr = pc_reg_q;
        pc             = pc_q;
        instruction    = instruction_q;
        valid          = valid_q;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns word == address; readiness is
// driven step by step to model zero-wait and wait-state memories.
module tb_if_stage;

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
    logic [1:0]  dbg_state;

    int total;
    int bad;

    if_stage_if bus ();

    assign bus.imem_ready = ready;
    assign bus.imem_rdata = bus.imem_addr;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (bus),
        .pc           (pc),
        .instruction  (instruction),
        .valid        (valid),
        .dbg_state    (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_pc,
                            input logic [31:0] e_instr, input logic e_valid);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".instr"}, instruction, e_instr);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        ready        = 1'b1;

        // Reset state, with freeze/branch asserted to show reset overrides them
        step();
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0800;
        step();
        chk_ifid("reset", 32'd0, 32'd0, 1'b0);
        chk("reset.req", {31'd0, bus.imem_req}, 32'd0);
        chk("reset.addr", bus.imem_addr, 32'd0);
        chk("reset.state", {30'd0, dbg_state}, {30'd0, S_FETCH});

        // Zero-wait streaming
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        #1;
        chk("run.req", {31'd0, bus.imem_req}, 32'd1);
        step();
        chk_ifid("zw0", 32'd4, 32'd0, 1'b1);
        step();
        chk_ifid("zw1", 32'd8, 32'd4, 1'b1);
        chk("zw1.addr", bus.imem_addr, 32'd8);

        // Freeze three cycles during fetch of 8
        freeze = 1'b1;
        step();
        chk_ifid("frz0", 32'd8, 32'd4, 1'b1);
        chk("frz0.state", {30'd0, dbg_state}, {30'd0, S_HOLD});
        chk("frz0.req", {31'd0, bus.imem_req}, 32'd0);
        step();
        step();
        chk_ifid("frz2", 32'd8, 32'd4, 1'b1);
        chk("frz2.state", {30'd0, dbg_state}, {30'd0, S_HOLD});
        freeze = 1'b0;
        step();
        chk_ifid("rel0", 32'd12, 32'd8, 1'b1);
        chk("rel0.addr", bus.imem_addr, 32'd12);
        step();
        chk_ifid("rel1", 32'd16, 32'd12, 1'b1);

        // Branch with ready memory
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0100;
        step();
        chk_ifid("br0", 32'd0, 32'd0, 1'b0);
        chk("br0.addr", bus.imem_addr, 32'h100);
        branch_taken = 1'b0;
        step();
        chk_ifid("br1", 32'h104, 32'h100, 1'b1);

        // Wait-state memory: branch to 0x200 while 0x10 is pending
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0010;
        step();
        branch_taken = 1'b0;
        ready        = 1'b0;
        step();
        chk_ifid("ws.bubble", 32'd0, 32'd0, 1'b0);
        chk("ws.addr0", bus.imem_addr, 32'h10);
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0200;
        step();
        chk("ws.state", {30'd0, dbg_state}, {30'd0, S_DISCARD});
        chk("ws.addr1", bus.imem_addr, 32'h10);
        chk("ws.req", {31'd0, bus.imem_req}, 32'd1);
        branch_taken = 1'b0;
        ready        = 1'b1;
        step();
        chk_ifid("ws.drop", 32'd0, 32'd0, 1'b0);
        chk("ws.addr2", bus.imem_addr, 32'h200);
        chk("ws.state2", {30'd0, dbg_state}, {30'd0, S_FETCH});
        step();
        chk_ifid("ws.next", 32'h204, 32'h200, 1'b1);

        // Branch and freeze together while in HOLD
        freeze = 1'b1;
        step();
        chk("hb.state", {30'd0, dbg_state}, {30'd0, S_HOLD});
        chk_ifid("hb.held", 32'h204, 32'h200, 1'b1);
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0400;
        step();
        chk_ifid("hb.clr", 32'd0, 32'd0, 1'b0);
        chk("hb.addr", bus.imem_addr, 32'h400);
        chk("hb.req", {31'd0, bus.imem_req}, 32'd1);
        branch_taken = 1'b0;
        freeze       = 1'b0;
        step();
        chk_ifid("hb.next", 32'h404, 32'h400, 1'b1);

        // Reset pulsed while in DISCARD
        ready        = 1'b0;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0500;
        step();
        chk("rd.state", {30'd0, dbg_state}, {30'd0, S_DISCARD});
        branch_taken = 1'b0;
        rst          = 1'b1;
        ready        = 1'b1;
        step();
        chk("rd.addr", bus.imem_addr, 32'd0);
        chk_ifid("rd.clr", 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        step();
        chk_ifid("rd.first", 32'd4, 32'd0, 1'b1);

        // Address wrap at the top of memory
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        step();
        chk_ifid("wrap", 32'd0, 32'hFFFF_FFFC, 1'b1);
        chk("wrap.addr", bus.imem_addr, 32'd0);

        // Freeze with memory not ready holds IF/ID in FETCH
        ready  = 1'b0;
        freeze = 1'b1;
        step();
        chk_ifid("fnr", 32'd0, 32'hFFFF_FFFC, 1'b1);
        chk("fnr.state", {30'd0, dbg_state}, {30'd0, S_FETCH});
        ready  = 1'b1;
        freeze = 1'b0;
        step();
        chk_ifid("fnr.next", 32'd4, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
